// File: rtl/mem_if_pkg.sv
// Shared line-memory interface definitions: address/line widths and responder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_if_pkg;
  localparam int MEM_ADDR_W = 28;
  localparam int MEM_LINE_W = 128;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_responder_array.sv
// Line storage: single port, synchronous write, combinational read, no reset on contents.
// Latency: write lands at the clock edge, read data follows the address combinationally.
// Backpressure: none; the owning FSM sequences every access.
module mem_responder_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_W-1:0]    addr,
  input  logic [MEM_LINE_W-1:0] wdata,
  output logic [MEM_LINE_W-1:0] rdata
);

  logic [MEM_LINE_W-1:0] lines [0:(1<<DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (we) lines[addr] <= wdata;
  end

  assign rdata = lines[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder (IDLE/BUSY/RESP); optional protocol checker under MEM_RESPONDER_CHECK_EN.
// Latency: mem_ready is high in the LATENCY-th cycle after the sampling edge, for exactly one cycle.
// Backpressure: initiator holds mem_read/mem_write until mem_ready; requests during RESP are ignored.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH_W = 10
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_LINE_W-1:0] mem_wdata,
  output logic [MEM_LINE_W-1:0] mem_rdata,
  output logic                  mem_ready
`ifdef MEM_RESPONDER_CHECK_EN
  ,
  output logic                  proto_err
`endif
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [MEM_ADDR_W-1:0] lat_addr;
  logic [MEM_LINE_W-1:0] lat_wdata;
  logic                  lat_wr;

  logic                  req;
  logic                  enter_resp;
  logic                  op_wr;
  logic                  arr_we;
  logic [DEPTH_W-1:0]    arr_addr;
  logic [MEM_LINE_W-1:0] arr_wdata;
  logic [MEM_LINE_W-1:0] arr_rdata;

  assign req = mem_read | mem_write;

  // With LATENCY=1 the access completes on the sampling edge, so the live inputs feed the array.
  always_comb begin
    enter_resp = 1'b0;
    op_wr      = lat_wr;
    arr_addr   = lat_addr[DEPTH_W-1:0];
    arr_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (LATENCY == 1) begin
          enter_resp = req;
          op_wr      = mem_write;
          arr_addr   = mem_addr[DEPTH_W-1:0];
          arr_wdata  = mem_wdata;
        end
      end
      BUSY:    enter_resp = (cnt == CNT_W'(1));
      default: enter_resp = 1'b0;
    endcase
  end

  assign arr_we = enter_resp & op_wr & ~proc_reset;

  mem_responder_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end else begin
      mem_ready <= enter_resp;
      if (enter_resp && !op_wr) mem_rdata <= arr_rdata;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_wr    <= mem_write;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_CHECK_EN
  // Sticky flag: conflicting op, address drift, or request drop while the access is in flight.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      proto_err <= 1'b0;
    end else if (state == IDLE && mem_read && mem_write) begin
      proto_err <= 1'b1;
    end else if (state == BUSY &&
                 ((mem_addr != lat_addr) || (lat_wr ? !mem_write : !mem_read))) begin
      proto_err <= 1'b1;
    end
  end
`else
  logic lat_addr_unused;
  assign lat_addr_unused = ^lat_addr[MEM_ADDR_W-1:DEPTH_W];
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: one instance at LATENCY=4, one at LATENCY=1.
// Expected responses come from a line-array model; a negedge monitor pops and compares.
module tb_mem_responder;
  import mem_if_pkg::*;

  localparam int DW = 10;

  typedef struct {
    int               exp_cyc;
    logic [127:0]     exp_data;
    logic             exp_perr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst   [2];
  logic         rd    [2];
  logic         wr    [2];
  logic [27:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
  logic         rdy   [2];
`ifdef MEM_RESPONDER_CHECK_EN
  logic         perr  [2];
`endif

  int           lat [2] = '{4, 1};
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [127:0] model    [2][1024];
  bit           valid    [2][1024];
  logic [127:0] last_rd  [2];
  bit           perr_exp [2];
  logic         prev_rdy [2];
  exp_t         sbq0[$];
  exp_t         sbq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.LATENCY(4), .DEPTH_W(DW)) u_dut0 (
    .clk(clk), .proc_reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(rdy[0])
`ifdef MEM_RESPONDER_CHECK_EN
    , .proto_err(perr[0])
`endif
  );

  mem_responder #(.LATENCY(1), .DEPTH_W(DW)) u_dut1 (
    .clk(clk), .proc_reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(rdy[1])
`ifdef MEM_RESPONDER_CHECK_EN
    , .proto_err(perr[1])
`endif
  );

  function automatic int qsize(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? sbq0[0] : sbq1[0];
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
  endtask

  task automatic qclear(input int d);
    if (d == 0) sbq0.delete(); else sbq1.delete();
  endtask

  task automatic chk(input string name, input int d, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", name, d, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int d);
    checks++;
    errors++;
    $display("FAIL %s dut%0d at cycle %0d", name, d, cyc);
  endtask

  // Monitor: pops one expectation per mem_ready pulse and checks timing, data and error flag.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        if (rdy[d]) begin
          chk("ready_consecutive", d, 128'(prev_rdy[d]), 128'(0));
          if (qsize(d) == 0) begin
            fail_now("unexpected_ready", d);
          end else begin
            chk("ready_cycle", d, 128'(cyc), 128'(qfront(d).exp_cyc));
            chk("rdata", d, rdata[d], qfront(d).exp_data);
`ifdef MEM_RESPONDER_CHECK_EN
            chk("proto_err", d, 128'(perr[d]), 128'(qfront(d).exp_perr));
`endif
            qpop(d);
          end
        end else if (qsize(d) != 0 && cyc > qfront(d).exp_cyc) begin
          fail_now("ready_timeout", d);
          qpop(d);
        end
      end
      prev_rdy[d] = rdy[d];
    end
  end

  // Issue one request at posedge+1 and wait for its response; a perturbed request
  // moves address and data while the access is in BUSY.
  task automatic do_req(input int d, input bit r, input bit w, input logic [27:0] a,
                        input logic [127:0] wd, input bit perturb, input bit keep);
    exp_t e;
    int   idx;
    int   n;
    idx = int'(a[DW-1:0]);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    if (r && w) perr_exp[d] = 1'b1;
    if (perturb && lat[d] > 1) perr_exp[d] = 1'b1;
    if (w) begin
      model[d][idx] = wd;
      valid[d][idx] = 1'b1;
    end else begin
      last_rd[d] = model[d][idx];
    end
    e.exp_cyc  = cyc + lat[d];
    e.exp_data = last_rd[d];
    e.exp_perr = perr_exp[d];
    qpush(d, e);
    if (perturb && lat[d] > 1) begin
      @(posedge clk); @(posedge clk); #1;
      addr[d]  = a + 28'd1;
      wdata[d] = ~wd;
    end
    n = 0;
    while (qsize(d) != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (qsize(d) != 0) begin
      fail_now("driver_wait", d);
      qclear(d);
    end
    if (!keep) begin
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
  endtask

  task automatic apply_reset(input int d);
    rst[d] = 1'b1;
    rd[d]  = 1'b0; wr[d] = 1'b0;
    #1;
    chk("reset_ready", d, 128'(rdy[d]), 128'(0));
    chk("reset_rdata", d, rdata[d], 128'(0));
`ifdef MEM_RESPONDER_CHECK_EN
    chk("reset_proto_err", d, 128'(perr[d]), 128'(0));
`endif
    qclear(d);
    perr_exp[d] = 1'b0;
    last_rd[d]  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
  endtask

  task automatic random_phase(input int d, input int nops);
    logic [27:0]  a;
    logic [127:0] wd;
    int           op;
    bit           keep;
    for (int i = 0; i < nops; i++) begin
      a       = 28'($urandom());
      a[DW-1:0] = DW'($urandom_range(0, 31));
      wd      = {$urandom(), $urandom(), $urandom(), $urandom()};
      op      = $urandom_range(0, 9);
      keep    = (i != nops - 1) && ($urandom_range(0, 1) == 1);
      if (op <= 3 && !valid[d][int'(a[DW-1:0])]) op = 4;
      if (op <= 3)      do_req(d, 1'b1, 1'b0, a, wd, 1'b0, keep);
      else if (op <= 7) do_req(d, 1'b0, 1'b1, a, wd, 1'b0, keep);
      else if (op == 8) do_req(d, 1'b1, 1'b1, a, wd, 1'b0, keep);
      else if (valid[d][int'(a[DW-1:0])] && a[DW-1:0] != DW'(1023))
        do_req(d, 1'b1, 1'b0, a, wd, (d == 0), keep);
      else              do_req(d, 1'b0, 1'b1, a, wd, 1'b0, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0; perr_exp[d] = 1'b0; prev_rdy[d] = 1'b0;
    end
    @(posedge clk); #1;

    // LATENCY=4 instance: basic write/read, conflict, aliasing, address drift, reset abort.
    apply_reset(0);
    do_req(0, 1'b0, 1'b1, 28'h0000010, a5, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b1, 28'h0000003, 128'h11, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b0, 28'h0000003, '0, 1'b0, 1'b0);
    do_req(0, 1'b0, 1'b1, 28'h0000400, 128'hBEEF, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b0, 28'h0000000, '0, 1'b0, 1'b0);
    do_req(0, 1'b0, 1'b1, 28'h0000007, 128'h7777, 1'b0, 1'b0);
    do_req(0, 1'b0, 1'b1, 28'h0000008, 128'h8888, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b0, 28'h0000007, '0, 1'b1, 1'b0);
    do_req(0, 1'b0, 1'b1, 28'h0000005, 128'h5555, 1'b0, 1'b0);
    do_req(0, 1'b1, 1'b0, 28'h0000007, '0, 1'b0, 1'b0);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 28'h0000005; wdata[0] = 128'hDEAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    apply_reset(0);
    do_req(0, 1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0);

    // LATENCY=1 instance: held back-to-back reads must alternate mem_ready.
    apply_reset(1);
    do_req(1, 1'b0, 1'b1, 28'h0000001, 128'h1111, 1'b0, 1'b0);
    do_req(1, 1'b0, 1'b1, 28'h0000002, 128'h2222, 1'b0, 1'b1);
    do_req(1, 1'b1, 1'b0, 28'h0000001, '0, 1'b0, 1'b1);
    do_req(1, 1'b1, 1'b0, 28'h0000002, '0, 1'b0, 1'b1);
    do_req(1, 1'b1, 1'b0, 28'h0000002, '0, 1'b0, 1'b1);
    do_req(1, 1'b1, 1'b0, 28'h0000001, '0, 1'b0, 1'b0);

    fork
      random_phase(0, 120);
      random_phase(1, 160);
    join

    repeat (6) @(posedge clk);
    #1;
    chk("drain_q", 0, 128'(qsize(0)), 128'(0));
    chk("drain_q", 1, 128'(qsize(1)), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request sample to mem_ready; legal 1..15.
REQ-002 SHALL have parameter DEPTH_W, default 10, log2 of stored lines.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port proc_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_read, input, 1, line read request, held by initiator until mem_ready.
REQ-006 SHALL have port mem_write, input, 1, line write request, held by initiator until mem_ready.
REQ-007 SHALL have port mem_addr, input, 28, line address.
REQ-008 SHALL have port mem_wdata, input, 128, write line.
REQ-009 SHALL have port mem_rdata, output, 128, read line, registered.
REQ-010 SHALL have port mem_ready, output, 1, one-cycle completion pulse, registered.

Function
REQ-011 SHALL implement states IDLE, BUSY, RESP.
- IDLE: mem_read or mem_write high at an edge. Latch mem_addr, mem_wdata and op. Go to BUSY with counter = LATENCY-1.
- LATENCY=1: IDLE goes directly to RESP.
REQ-012 BUSY SHALL decrement the counter each edge and go to RESP on the edge where the counter is 0.
- mem_ready SHALL be high exactly in the cycle LATENCY edges after the sampling edge.
REQ-013 RESP SHALL last one cycle, then go to IDLE unconditionally.
- Requests present during RESP are ignored.
- A request still high in the following IDLE cycle is sampled as a new request.
REQ-014 Read: mem_rdata SHALL equal stored line [latched addr] during the mem_ready cycle.
- mem_rdata holds that value until the next read completes.
REQ-015 Write: latched wdata SHALL be stored at the edge entering RESP.
- mem_rdata is unchanged by writes.
- A read of the same line issued afterwards returns the new data.
REQ-016 Storage index SHALL be latched addr[DEPTH_W-1:0].
- Higher address bits are ignored, so addresses alias.
REQ-017 mem_read and mem_write both sampled high: the write SHALL win and the read is dropped.
REQ-018 Address or data changes during BUSY/RESP SHALL have no effect; the latched values are used.
REQ-019 mem_ready SHALL never be high in two consecutive cycles.

Reset
REQ-020 Asserting proc_reset at any time SHALL set state to IDLE, counter 0, mem_ready 0, mem_rdata 0, and abort any in-flight request.
- An aborted write SHALL not modify storage.
REQ-021 Storage contents SHALL NOT be reset.
- Reads of never-written lines return X in simulation.
REQ-022 The first request SHALL be sampled at the first rising edge after proc_reset deasserts.

Configuration
REQ-023 Macro MEM_RESPONDER_CHECK_EN defined: SHALL add output proto_err (1 bit, reset 0, sticky until reset).
- Set when, in BUSY, mem_addr differs from the latched address.
- Set when, in BUSY, the latched request's signal drops before mem_ready.
- Set when mem_read and mem_write are sampled high together in IDLE.
REQ-024 Macro undefined: proto_err port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-025 Shared package mem_if_pkg SHALL hold MEM_ADDR_W=28, MEM_LINE_W=128 and the state enum.
REQ-026 Storage SHALL be sub-module mem_responder_array: single port, synchronous write, combinational read; the FSM and counter stay in mem_responder.

Verification
REQ-027 Reset, LATENCY=4: write addr 0x0000010 data 0xA5..A5 -> mem_ready high exactly 4 cycles after the sample; then read 0x0000010 -> mem_rdata 0xA5..A5 with mem_ready.
REQ-028 LATENCY=1: back-to-back reads of 0x1 and 0x2, requests held -> mem_ready pulses in alternate cycles, never two consecutive cycles high.
REQ-029 mem_read and mem_write high together, addr 0x3, wdata 0x11 -> line 3 = 0x11; mem_rdata unchanged; proto_err=1 when the macro is defined.
REQ-030 proc_reset asserted mid-BUSY of a write to 0x5 -> mem_ready never pulses; line 5 keeps its old value; outputs 0 immediately.
REQ-031 DEPTH_W=10: write 0x0000400 with 0xBEEF, read 0x0000000 -> 0xBEEF (alias).
REQ-032 mem_addr changed during BUSY from 0x7 to 0x8 -> the response is for 0x7; proto_err=1 when the macro is defined.
